// File: rtl/counter_modn_pkg.sv
// counter_pkg: shared types and helpers for the modulo-N counter slice.
//   cnt_mode_t : decodes the sat_mode input (wrap / saturate).
//   cnt_width  : clog2-based width of a counter that must hold 0 .. n-1,
//                never narrower than one bit.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/counter_modn_if.sv
// counter_modn_if: control and status bundle of counter_modn.
//   master : drives clear/load/data_in/enable/up/sat_mode, observes status.
//   slave  : the counter itself; drives count/tc/wrap/ovf/load_err.
interface counter_modn_if #(
    parameter int unsigned NBITS = 4
);
    logic             clear;
    logic             load;
    logic [NBITS-1:0] data_in;
    logic             enable;
    logic             up;
    logic             sat_mode;
    logic [NBITS-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;
    logic             load_err;

    modport master (
        output clear, load, data_in, enable, up, sat_mode,
        input  count, tc, wrap, ovf, load_err
    );

    modport slave (
        input  clear, load, data_in, enable, up, sat_mode,
        output count, tc, wrap, ovf, load_err
    );
endinterface

// File: rtl/counter_modn_prescaler.sv
// prescaler_tick: divides the enable stream by PRESCALE.
//   clk_2   : clock, rising edge.
//   reset_n : asynchronous active-low reset.
//   clear   : synchronous return of the phase counter to 0.
//   enable  : advances the phase counter; counter holds while low.
//   tick    : high on the enabled cycle where the phase counter is at PRESCALE-1.
module prescaler_tick
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk_2,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int unsigned PW = cnt_width(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre;
    logic          w_last;

    // With PRESCALE = 1 r_pre is pinned at 0, so tick collapses to enable.
    assign w_last = (r_pre == PRE_LAST);
    assign tick   = enable && w_last;

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
        end else if (clear) begin
            r_pre <= '0;
        end else if (enable) begin
            r_pre <= w_last ? '0 : r_pre + PW'(1);
        end
    end
endmodule

// File: rtl/counter_modn.sv
// counter_modn: modulo-MODULUS up/down counter with prescaler,
// wrap/saturate limit handling and cascade support.
//   clk_2   : clock, rising edge.
//   reset_n : asynchronous active-low reset.
//   bus     : counter_modn_if.slave
//             in : clear, load, data_in, enable, up, sat_mode
//             out: count, tc (combinational), wrap, ovf (sticky), load_err
module counter_modn
    import counter_pkg::*;
#(
    parameter int unsigned MODULUS  = 10,
    parameter int unsigned NBITS    = cnt_width(MODULUS),
    parameter int unsigned PRESCALE = 1
) (
    input  logic           clk_2,
    input  logic           reset_n,
    counter_modn_if.slave  bus
);
    localparam logic [NBITS-1:0] CNT_MAX = NBITS'(MODULUS - 1);
    localparam logic [NBITS:0]   CNT_LIM = (NBITS + 1)'(MODULUS);

    logic [NBITS-1:0] r_count;
    logic             r_wrap;
    logic             r_ovf;
    logic             r_load_err;

    logic             w_tick;
    logic             w_tc;
    logic             w_load_ok;
    logic             w_pre_clear;
    logic             w_pre_en;
    logic             w_cascade;
    cnt_mode_t        w_mode;

    assign w_mode    = cnt_mode_t'(bus.sat_mode);
    assign w_load_ok = ({1'b0, bus.data_in} < CNT_LIM);

    // Any load freezes the prescaler: an accepted one restarts it, a
    // rejected one must leave it holding.
    assign w_pre_clear = bus.clear || (bus.load && w_load_ok);
    assign w_pre_en    = bus.enable && !bus.load;

    prescaler_tick #(
        .PRESCALE (PRESCALE)
    ) u_pre (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .clear   (w_pre_clear),
        .enable  (w_pre_en),
        .tick    (w_tick)
    );

    always_comb begin
        w_tc = (bus.up && (r_count == CNT_MAX)) || (!bus.up && (r_count == '0));
    end

    // Next-stage enable; it is also exactly the "step attempted at the limit"
    // condition, so the core uses it to select the limit branch.
    assign w_cascade = w_tc && w_tick;

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_ovf      <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
            if (bus.clear) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (bus.load) begin
                if (w_load_ok) begin
                    r_count <= bus.data_in;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (w_cascade) begin
                r_ovf <= 1'b1;
                if (w_mode == CNT_WRAP) begin
                    r_count <= bus.up ? '0 : CNT_MAX;
                    r_wrap  <= 1'b1;
                end
            end else if (w_tick) begin
                r_count <= bus.up ? r_count + NBITS'(1) : r_count - NBITS'(1);
            end
        end
    end

    assign bus.count    = r_count;
    assign bus.tc       = w_tc;
    assign bus.wrap     = r_wrap;
    assign bus.ovf      = r_ovf;
    assign bus.load_err = r_load_err;
endmodule

// File: tb/tb_counter_modn.sv
module tb_counter_modn;

    logic clk;
    logic rst_a;
    logic rst_b;

    counter_modn_if #(.NBITS(4)) ifa ();
    counter_modn_if #(.NBITS(4)) ifb ();

    counter_modn #(
        .MODULUS  (10),
        .NBITS    (4),
        .PRESCALE (1)
    ) dut_a (
        .clk_2   (clk),
        .reset_n (rst_a),
        .bus     (ifa)
    );

    counter_modn #(
        .MODULUS  (10),
        .NBITS    (4),
        .PRESCALE (3)
    ) dut_b (
        .clk_2   (clk),
        .reset_n (rst_b),
        .bus     (ifb)
    );

    typedef struct {
        int        sel;
        logic [3:0] cnt;
        logic      tc;
        logic      wrap;
        logic      ovf;
        logic      lerr;
        string     name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    event sample;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        -> sample;
    end

    // Monitor: pops one expectation per sample point and compares.
    initial begin
        exp_t       e;
        logic [3:0] a_cnt;
        logic       a_tc, a_wrap, a_ovf, a_lerr;
        forever begin
            @(sample);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.sel == 0) begin
                    a_cnt = ifa.count; a_tc = ifa.tc; a_wrap = ifa.wrap;
                    a_ovf = ifa.ovf;   a_lerr = ifa.load_err;
                end else begin
                    a_cnt = ifb.count; a_tc = ifb.tc; a_wrap = ifb.wrap;
                    a_ovf = ifb.ovf;   a_lerr = ifb.load_err;
                end
                checks++;
                if (a_cnt !== e.cnt || a_tc !== e.tc || a_wrap !== e.wrap ||
                    a_ovf !== e.ovf || a_lerr !== e.lerr) begin
                    errors++;
                    $display("FAIL %s: got cnt=%0d tc=%b wrap=%b ovf=%b lerr=%b, expected cnt=%0d tc=%b wrap=%b ovf=%b lerr=%b",
                             e.name, a_cnt, a_tc, a_wrap, a_ovf, a_lerr,
                             e.cnt, e.tc, e.wrap, e.ovf, e.lerr);
                end
            end
        end
    end

    task automatic push(input int sel, input logic [3:0] c, input logic t,
                        input logic w, input logic o, input logic l,
                        input string nm);
        exp_t e;
        e.sel = sel; e.cnt = c; e.tc = t; e.wrap = w; e.ovf = o; e.lerr = l;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the state
    // expected after the following rising edge.
    task automatic cyc(input int sel, input logic clr, input logic ld,
                       input logic [3:0] din, input logic en, input logic u,
                       input logic s, input logic [3:0] ec, input logic et,
                       input logic ew, input logic eo, input logic el,
                       input string nm);
        @(negedge clk);
        if (sel == 0) begin
            ifa.clear = clr; ifa.load = ld; ifa.data_in = din;
            ifa.enable = en; ifa.up = u; ifa.sat_mode = s;
        end else begin
            ifb.clear = clr; ifb.load = ld; ifb.data_in = din;
            ifb.enable = en; ifb.up = u; ifb.sat_mode = s;
        end
        push(sel, ec, et, ew, eo, el, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        ifa.clear = 0; ifa.load = 0; ifa.data_in = '0; ifa.enable = 0; ifa.up = 0; ifa.sat_mode = 0;
        ifb.clear = 0; ifb.load = 0; ifb.data_in = '0; ifb.enable = 0; ifb.up = 0; ifb.sat_mode = 0;

        #2;
        push(0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, "reset_a");
        -> sample;
        #1;
        push(1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, "reset_b");
        -> sample;
        #4;
        rst_a = 1'b1; rst_b = 1'b1;

        // Up count with wrap from reset.
        for (int k = 1; k <= 9; k++)
            cyc(0, 0, 0, 4'd0, 1, 1, 0, 4'(k), (k == 9), 0, 0, 0, "t1_up");
        cyc(0, 0, 0, 4'd0, 1, 1, 0, 4'd0, 0, 1, 1, 0, "t1_wrap");
        cyc(0, 0, 0, 4'd0, 1, 1, 0, 4'd1, 0, 0, 1, 0, "t1_after");

        // Down count, saturate.
        cyc(0, 1, 0, 4'd0, 1, 0, 1, 4'd0, 1, 0, 0, 0, "t2_clear");
        cyc(0, 0, 1, 4'd2, 1, 0, 1, 4'd2, 0, 0, 0, 0, "t2_load2");
        cyc(0, 0, 0, 4'd0, 1, 0, 1, 4'd1, 0, 0, 0, 0, "t2_dn1");
        cyc(0, 0, 0, 4'd0, 1, 0, 1, 4'd0, 1, 0, 0, 0, "t2_dn0");
        cyc(0, 0, 0, 4'd0, 1, 0, 1, 4'd0, 1, 0, 1, 0, "t2_hold");
        cyc(0, 0, 0, 4'd0, 1, 0, 1, 4'd0, 1, 0, 1, 0, "t2_hold2");

        // Out-of-range load rejected.
        cyc(0, 0, 1, 4'd5,  0, 1, 0, 4'd5, 0, 0, 1, 0, "t3_load5");
        cyc(0, 0, 1, 4'd12, 1, 1, 0, 4'd5, 0, 0, 1, 1, "t3_bad");
        cyc(0, 0, 1, 4'd7,  1, 1, 0, 4'd7, 0, 0, 1, 0, "t3_load7");
        cyc(0, 0, 0, 4'd0,  0, 1, 0, 4'd7, 0, 0, 1, 0, "t3_idle");

        // Priority clear > load > step.
        cyc(0, 0, 1, 4'd9, 0, 1, 0, 4'd9, 1, 0, 1, 0, "t5_load9");
        cyc(0, 1, 1, 4'd3, 1, 1, 0, 4'd0, 0, 0, 0, 0, "t5_clr_ld_tick");
        cyc(0, 0, 1, 4'd9, 0, 1, 0, 4'd9, 1, 0, 0, 0, "t5_reload9");
        cyc(0, 0, 1, 4'd4, 1, 1, 0, 4'd4, 0, 0, 0, 0, "t5_ld_tick");

        // Down wrap.
        cyc(0, 0, 1, 4'd0, 0, 0, 0, 4'd0, 1, 0, 0, 0, "t7_load0");
        cyc(0, 0, 0, 4'd0, 1, 0, 0, 4'd9, 0, 1, 1, 0, "t7_dnwrap");
        cyc(0, 0, 0, 4'd0, 1, 0, 0, 4'd8, 0, 0, 1, 0, "t7_dn");

        // Prescale 3.
        for (int k = 1; k <= 9; k++)
            cyc(1, 0, 0, 4'd0, 1, 1, 0, 4'(k / 3), 0, 0, 0, 0, "t4_pre");
        cyc(1, 1, 0, 4'd0, 1, 1, 0, 4'd0, 0, 0, 0, 0, "t4_clear");
        cyc(1, 0, 0, 4'd0, 1, 1, 0, 4'd0, 0, 0, 0, 0, "t4_e1");
        cyc(1, 0, 0, 4'd0, 1, 1, 0, 4'd0, 0, 0, 0, 0, "t4_e2");
        cyc(1, 0, 0, 4'd0, 1, 1, 0, 4'd1, 0, 0, 0, 0, "t4_e3");
        cyc(1, 0, 0, 4'd0, 1, 1, 0, 4'd1, 0, 0, 0, 0, "t4_e4");
        cyc(1, 0, 0, 4'd0, 0, 1, 0, 4'd1, 0, 0, 0, 0, "t4_gap1");
        cyc(1, 0, 0, 4'd0, 0, 1, 0, 4'd1, 0, 0, 0, 0, "t4_gap2");
        cyc(1, 0, 0, 4'd0, 1, 1, 0, 4'd1, 0, 0, 0, 0, "t4_e5");
        cyc(1, 0, 0, 4'd0, 1, 1, 0, 4'd2, 0, 0, 0, 0, "t4_e6");
        cyc(1, 0, 0, 4'd0, 1, 1, 0, 4'd2, 0, 0, 0, 0, "t4_e7");

        // Saturate at top with prescale, then async reset mid-prescale.
        cyc(1, 0, 1, 4'd9, 0, 1, 1, 4'd9, 1, 0, 0, 0, "t6_load9");
        cyc(1, 0, 0, 4'd0, 1, 1, 1, 4'd9, 1, 0, 0, 0, "t6_sat1");
        cyc(1, 0, 0, 4'd0, 1, 1, 1, 4'd9, 1, 0, 0, 0, "t6_sat2");
        cyc(1, 0, 0, 4'd0, 1, 1, 1, 4'd9, 1, 0, 1, 0, "t6_sat3");
        cyc(1, 0, 1, 4'd6, 0, 1, 1, 4'd6, 0, 0, 1, 0, "t6_load6");
        cyc(1, 0, 0, 4'd0, 1, 1, 1, 4'd6, 0, 0, 1, 0, "t6_mid");
        @(posedge clk);
        #2;
        rst_b = 1'b0;
        push(1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "t6_async");
        #1;
        -> sample;
        #1;
        rst_b = 1'b1;
        cyc(1, 0, 0, 4'd0, 1, 1, 1, 4'd0, 0, 0, 0, 0, "t6_rel1");
        cyc(1, 0, 0, 4'd0, 1, 1, 1, 4'd0, 0, 0, 0, 0, "t6_rel2");
        cyc(1, 0, 0, 4'd0, 1, 1, 1, 4'd1, 0, 0, 0, 0, "t6_rel3");

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_modn.md
# counter_modn

Parametrised modulo-N up/down counter that generalises the fixed modulo-4 counter used on the board tops. It adds:

- a configurable modulus;
- wrap or saturate mode;
- a built-in enable prescaler;
- a terminal-count output and a registered wrap pulse, so stages can cascade;
- sticky overflow and load-error flags.

It sits between the SWI/LED glue in `top` and any logic that needs a slow, bounded count.

## Interface

Parameters:
- `MODULUS`, 10: count range is 0 .. MODULUS-1; legal range is ≥ 2.
- `NBITS`, $clog2(MODULUS): width of the count and load data.
- `PRESCALE`, 1: number of enabled cycles per count step; legal range is ≥ 1.

Ports:
- `clk_2`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous clear of count, prescaler and sticky flags.
- `load`  in  1  synchronous load of `data_in`.
- `data_in`  in  NBITS  load value.
- `enable`  in  1  counting enable, fed to the prescaler.
- `up`  in  1  direction: 1 counts up, 0 counts down.
- `sat_mode`  in  1  limit behaviour: 0 wraps, 1 saturates.
- `count`  out  NBITS  current count (registered).
- `tc`  out  1  terminal count (combinational from `count` and `up`).
- `wrap`  out  1  one-cycle pulse on a wrap (registered).
- `ovf`  out  1  sticky flag: a step was attempted at the limit.
- `load_err`  out  1  one-cycle pulse when an out-of-range load is rejected (registered).

## Operation

- **Priority each edge:** `reset_n` low > `clear` > `load` > step.
- **Reset (`reset_n` = 0):** `count` = 0, prescaler = 0, `wrap` = 0, `ovf` = 0, `load_err` = 0. Reset acts immediately and asynchronously, including mid-count or mid-prescale.
- **`clear`:** same values as reset, applied synchronously.
- **`load` with `data_in` < MODULUS:** `count` ← `data_in` and prescaler ← 0.
- **`load` with `data_in` ≥ MODULUS:** `count` and prescaler hold, and `load_err` pulses for 1 cycle.
- **Prescaler:**
  - Internal counter `pre` runs 0 .. PRESCALE-1 and advances only while `enable` = 1.
  - `tick` = `enable` && (`pre` == PRESCALE-1); on `tick`, `pre` ← 0.
  - With PRESCALE = 1, `tick` = `enable`.
  - `pre` holds while `enable` = 0.
- **Step (on `tick`, no clear or load):**
  - `up` = 1, `count` < MODULUS-1: `count` + 1.
  - `up` = 1, `count` = MODULUS-1: in wrap mode `count` ← 0, `wrap` ← 1 and `ovf` ← 1; in saturate mode `count` holds and `ovf` ← 1.
  - `up` = 0, `count` > 0: `count` - 1.
  - `up` = 0, `count` = 0: in wrap mode `count` ← MODULUS-1, `wrap` ← 1 and `ovf` ← 1; in saturate mode `count` holds and `ovf` ← 1.
- **`tc`:** (`up` && `count` == MODULUS-1) || (!`up` && `count` == 0). It reflects a direction change in the same cycle.
- **Arithmetic:** all in NBITS, unsigned, with no intermediate overflow, because the limit compare precedes the ±1.
- **Mode and direction changes:** `sat_mode` and `up` changes take effect at the next step; no state is flushed.

## Timing

- Count latency is 1 clock from the edge where `tick` is sampled to `count` updating.
- `wrap` and `load_err` are high for exactly the one cycle following the triggering edge.
- `wrap` is aligned with the wrapped `count` value.
- `ovf` rises together with the limit step and stays high until `clear` or reset.
- With PRESCALE = P and `enable` held high, `count` advances every P cycles. The first step comes P cycles after reset, clear or load.
- **Cascading:** the next stage's `enable` = `tc` && this stage's `tick`. That cascade tap is exported as an internal signal only; the ports above are final.

## Structure

- **Package `counter_pkg`:**
  - typedef enum `cnt_mode_t` {CNT_WRAP = 0, CNT_SAT = 1}, used to decode `sat_mode`;
  - a `clog2`-based width helper constant function.
- **Sub-module `prescaler_tick`** (parameter PRESCALE; ports `clk_2`, `reset_n`, `clear`, `enable`, `tick`):
  - instantiated once;
  - `clear` input driven by `clear` || accepted `load`.
- The counter core is a single `always_ff` with async reset, plus an `always_comb` for `tc`.

## Test plan

1. MODULUS = 10, PRESCALE = 1, `enable` = 1, `up` = 1, `sat_mode` = 0 from reset → `count` runs 0..9,0; `wrap` is high only in the cycle `count` returns to 0; `ovf` = 1 from then on.
2. Down count in saturate mode: load 2, `up` = 0, `sat_mode` = 1, `enable` = 1 → `count` goes 2,1,0,0,0; `wrap` never asserts; `ovf` sets on the first held 0; `tc` = 1 while `count` = 0.
3. Load 12 (≥ MODULUS) while `count` = 5 → `count` stays 5 and `load_err` pulses once. Then load 7 → `count` = 7 next cycle and `load_err` = 0.
4. PRESCALE = 3, `enable` = 1 → `count` steps on cycles 3, 6, 9. Dropping `enable` for 2 cycles after the 4th enabled cycle delays the next step by 2 cycles.
5. Priority: `clear`, `load` and `tick` in the same cycle with `count` = 9 and `ovf` = 1 → `count` = 0, `ovf` = 0, no `wrap`. With `load` + `tick` only → `count` = `data_in`.
6. Assert `reset_n` = 0 asynchronously mid-prescale with `count` = 6 → `count`, `wrap`, `ovf` and `load_err` go to 0 immediately. After release, the first step comes PRESCALE enabled cycles later.
